// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drain stage between an 8-bit FIFO read port and a UART TX pin.
//   Pops one byte whenever the FIFO is non-empty and the line is free, then
//   serialises it LSB first: start bit, 8 data bits, optional parity, stop bit.
//   The bit period is DIVISOR = CLK_FREQ / BAUD clocks.
//
//   Build option (macro FIFO_UART_TX_PARITY_EN):
//     defined   -> even parity bit after the data bits (8E1, 11 bit periods)
//     undefined -> no parity state and no parity logic (8N1, 10 bit periods)
//
//   tx, fifo_read, busy and tx_done are all driven straight from flops.
//   tx_done and a back-to-back pop are decided on the last clock of the stop
//   bit, so both appear together in the cycle that follows it.  The FETCH
//   and LOAD cycles then leave a two-clock idle gap before the next start bit.
module fifo_uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int CNT_W    = $clog2(CLK_FREQ / BAUD)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int               DIVISOR   = CLK_FREQ / BAUD;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BAUD_ZERO = {CNT_W{1'b0}};
  localparam logic [2:0]       BIT_LAST  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } state_t;

`ifdef FIFO_UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity8(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // Registered state and datapath
  state_t           state_r;
  logic [CNT_W-1:0] baud_r;
  logic [2:0]       bit_r;
  logic [7:0]       shift_r;
  logic             fifo_read_r;
  logic             tx_r;
  logic             busy_r;
  logic             tx_done_r;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_r;
`endif

  // Next-cycle values
  state_t           state_s;
  logic [CNT_W-1:0] baud_s;
  logic [2:0]       bit_s;
  logic [7:0]       shift_s;
  logic             fifo_read_s;
  logic             tx_s;
  logic             busy_s;
  logic             tx_done_s;
  logic             baud_last_s;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_s;
`endif

  assign baud_last_s = (baud_r == BAUD_LAST);

  assign fifo_read = fifo_read_r;
  assign tx        = tx_r;
  assign busy      = busy_r;
  assign tx_done   = tx_done_r;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, datapath and output decode; tx_s is the line level for the
  // state being entered, so the registered tx lines up with state_r.
  always_comb begin
    state_s     = state_r;
    baud_s      = baud_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_s    = parity_r;
`endif
    fifo_read_s = 1'b0;
    tx_s        = 1'b1;
    tx_done_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        baud_s = BAUD_ZERO;
        bit_s  = 3'd0;
        if (!fifo_empty) begin
          fifo_read_s = 1'b1;
          state_s     = ST_FETCH;
        end else begin
          state_s     = ST_IDLE;
        end
      end

      // fifo_read is high during this cycle; data arrives in the next one
      ST_FETCH: begin
        state_s = ST_LOAD;
      end

      // Capture the byte and restart the baud counter so the frame is aligned
      ST_LOAD: begin
        shift_s = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_s = even_parity8(fifo_data);
`endif
        baud_s  = BAUD_ZERO;
        bit_s   = 3'd0;
        tx_s    = 1'b0;
        state_s = ST_START;
      end

      ST_START: begin
        if (baud_last_s) begin
          baud_s  = BAUD_ZERO;
          tx_s    = shift_r[0];
          state_s = ST_DATA;
        end else begin
          baud_s  = baud_r + BAUD_ONE;
          tx_s    = 1'b0;
        end
      end

      ST_DATA: begin
        if (baud_last_s) begin
          baud_s  = BAUD_ZERO;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == BIT_LAST) begin
            bit_s   = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            tx_s    = parity_r;
            state_s = ST_PARITY;
`else
            tx_s    = 1'b1;
            state_s = ST_STOP;
`endif
          end else begin
            bit_s   = bit_r + 3'd1;
            tx_s    = shift_r[1];
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
          tx_s   = shift_r[0];
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last_s) begin
          baud_s  = BAUD_ZERO;
          tx_s    = 1'b1;
          state_s = ST_STOP;
        end else begin
          baud_s  = baud_r + BAUD_ONE;
          tx_s    = parity_r;
        end
      end
`endif

      // Last stop clock: flag completion and chain straight into the next
      // pop when the FIFO still holds data
      ST_STOP: begin
        if (baud_last_s) begin
          baud_s    = BAUD_ZERO;
          tx_done_s = 1'b1;
          if (!fifo_empty) begin
            fifo_read_s = 1'b1;
            state_s     = ST_FETCH;
          end else begin
            state_s     = ST_IDLE;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end

      default: begin
        baud_s  = BAUD_ZERO;
        bit_s   = 3'd0;
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // Datapath registers and registered outputs; reset aborts any frame and
  // drives the line high at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_r      <= BAUD_ZERO;
      bit_r       <= 3'd0;
      shift_r     <= 8'h00;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_r    <= 1'b0;
`endif
      fifo_read_r <= 1'b0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      tx_done_r   <= 1'b0;
    end else begin
      baud_r      <= baud_s;
      bit_r       <= bit_s;
      shift_r     <= shift_s;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_r    <= parity_s;
`endif
      fifo_read_r <= fifo_read_s;
      tx_r        <= tx_s;
      busy_r      <= busy_s;
      tx_done_r   <= tx_done_s;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx with DIVISOR = 10 (CLK_FREQ=100, BAUD=10).
// A small FIFO read-port model feeds the DUT; directed scenarios check the
// serial waveform cycle by cycle against hand-derived bit patterns.
module tb_fifo_uart_tx;

  localparam int DIV = 10;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_read;
  logic       tx;
  logic       busy;
  logic       tx_done;

  // FIFO model storage (written by the stimulus, read by the model)
  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr        = 4'd0;
  logic [3:0] rd_ptr        = 4'd0;
  logic       toggle_mode   = 1'b0;
  logic       toggle_val    = 1'b1;
  logic       model_en      = 1'b0;
  logic       empty_at_edge = 1'b1;
  int         read_cnt      = 0;
  int         underflow     = 0;

  int compared   = 0;
  int mismatched = 0;

  assign fifo_empty = toggle_mode ? toggle_val : (wr_ptr == rd_ptr);

  fifo_uart_tx #(
    .CLK_FREQ(100),
    .BAUD    (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_read (fifo_read),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Empty flag as sampled by the DUT on each rising edge
  always @(posedge clk) empty_at_edge = fifo_empty;

  // FIFO read port: a pop seen this cycle presents data before the next edge
  always @(negedge clk) begin
    if (model_en && fifo_read === 1'b1) begin
      read_cnt = read_cnt + 1;
      if (empty_at_edge || (wr_ptr == rd_ptr)) begin
        underflow = underflow + 1;
      end else begin
        fifo_data = mem[rd_ptr];
        rd_ptr    = rd_ptr + 4'd1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic wait_pop(input string name, input int limit);
    int n;
    n = 0;
    while (fifo_read !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (fifo_read !== 1'b1) begin
      mismatched++;
      $display("FAIL %s pop: fifo_read=%b after %0d clks, want 1", name, fifo_read, n);
    end
  endtask

  // Called on the negedge of the cycle where fifo_read is high; walks the
  // whole frame and finishes on the cycle where tx_done is expected.
  task automatic check_frame(input string name, input logic [7:0] data,
                             input logic exp_par, input bit toggle);
    logic       exp_tx;
    logic       prev_empty;
    logic [7:0] sh;
    int         idx;
    prev_empty = 1'b1;
    for (int c = 1; c <= FRAME + 2; c++) begin
      @(negedge clk);
      if (toggle) toggle_val = ~toggle_val;
      if (c < 2) begin
        exp_tx = 1'b1;
      end else begin
        idx = (c - 2) / DIV;
        if (idx == 0) begin
          exp_tx = 1'b0;
        end else if (idx <= 8) begin
          sh     = data >> (idx - 1);
          exp_tx = sh[0];
        end else if (idx == 9 && NBITS == 11) begin
          exp_tx = exp_par;
        end else begin
          exp_tx = 1'b1;
        end
      end
      compared++;
      if (tx !== exp_tx) begin
        mismatched++;
        $display("FAIL %s tx at clk %0d: got %b want %b", name, c, tx, exp_tx);
      end
      if (c <= FRAME + 1) begin
        compared++;
        if (busy !== 1'b1) begin
          mismatched++;
          $display("FAIL %s busy at clk %0d: got %b want 1", name, c, busy);
        end
        compared++;
        if (fifo_read !== 1'b0) begin
          mismatched++;
          $display("FAIL %s extra pop at clk %0d: got %b want 0", name, c, fifo_read);
        end
        compared++;
        if (tx_done !== 1'b0) begin
          mismatched++;
          $display("FAIL %s early tx_done at clk %0d: got %b want 0", name, c, tx_done);
        end
        prev_empty = toggle_mode ? toggle_val : (wr_ptr == rd_ptr);
      end else begin
        compared++;
        if (tx_done !== 1'b1) begin
          mismatched++;
          $display("FAIL %s tx_done at clk %0d: got %b want 1", name, c, tx_done);
        end
        compared++;
        if (fifo_read !== ~prev_empty) begin
          mismatched++;
          $display("FAIL %s chained pop: got %b want %b", name, fifo_read, ~prev_empty);
        end
        compared++;
        if (busy !== ~prev_empty) begin
          mismatched++;
          $display("FAIL %s busy after stop: got %b want %b", name, busy, ~prev_empty);
        end
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      compared++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0 || tx_done !== 1'b0) begin
        mismatched++;
        $display("FAIL %s idle clk %0d: tx/busy/rd/done=%b%b%b%b want 1000",
                 name, c, tx, busy, fifo_read, tx_done);
      end
    end
  endtask

  task automatic test_reset();
    #12 reset = 1'b1;
    #1;
    compared++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0 || tx_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset values: tx/busy/rd/done=%b%b%b%b want 1000", tx, busy, fifo_read, tx_done);
    end
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    model_en = 1'b1;
    check_idle("reset_hold", 200);
  endtask

  task automatic test_single();
    int r0;
    r0 = read_cnt;
    push(8'h47);
    wait_pop("single", 20);
    check_frame("single", 8'h47, 1'b0, 1'b0);
    check_idle("single_after", 20);
    compared++;
    if (read_cnt - r0 != 1) begin
      mismatched++;
      $display("FAIL single pop count: got %0d want 1", read_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = read_cnt;
    push(8'h47);
    push(8'hA5);
    push(8'h00);
    wait_pop("b2b", 20);
    check_frame("b2b_47", 8'h47, 1'b0, 1'b0);
    check_frame("b2b_A5", 8'hA5, 1'b0, 1'b0);
    check_frame("b2b_00", 8'h00, 1'b0, 1'b0);
    check_idle("b2b_after", 10);
    compared++;
    if (read_cnt - r0 != 3) begin
      mismatched++;
      $display("FAIL b2b pop count: got %0d want 3", read_cnt - r0);
    end
  endtask

  task automatic test_reset_mid_frame();
    push(8'hFF);
    wait_pop("midrst", 20);
    for (int c = 1; c <= 45; c++) @(negedge clk);
    compared++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst bit3: tx/busy=%b%b want 11", tx, busy);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0 || tx_done !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst async: tx/busy/rd/done=%b%b%b%b want 1000", tx, busy, fifo_read, tx_done);
    end
    @(negedge clk);
    reset = 1'b0;
    check_idle("midrst_lost", 30);
    push(8'h5A);
    wait_pop("midrst_next", 20);
    check_frame("midrst_5A", 8'h5A, 1'b0, 1'b0);
    check_idle("midrst_after", 5);
  endtask

  task automatic test_empty_toggle();
    push(8'h3C);
    push(8'hC3);
    wait_pop("toggle", 20);
    toggle_val  = 1'b1;
    toggle_mode = 1'b1;
    check_frame("toggle_3C", 8'h3C, 1'b0, 1'b1);
    toggle_mode = 1'b0;
    wait_pop("toggle_next", 20);
    check_frame("toggle_C3", 8'hC3, 1'b0, 1'b0);
    check_idle("toggle_after", 5);
    compared++;
    if (underflow != 0) begin
      mismatched++;
      $display("FAIL underflow count: got %0d want 0", underflow);
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    push(8'h47);
    wait_pop("par47", 20);
    check_frame("par47", 8'h47, 1'b0, 1'b0);
    check_idle("par_gap", 5);
    push(8'h07);
    wait_pop("par07", 20);
    check_frame("par07", 8'h07, 1'b1, 1'b0);
    check_idle("par_after", 5);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_empty_toggle();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    compared++;
    if (underflow != 0) begin
      mismatched++;
      $display("FAIL final underflow: got %0d want 0", underflow);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
